// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : ALU command codes and issuer FSM encoding shared with the ALU LUT.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_OR   = 3'd6,
    CMD_NOR  = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } issuer_state_e;

  localparam int SETTLE_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/alu_issuer.sv
// ============================================================================
// alu_issuer : holds operands on a combinational ALU for a fixed settle time,
//              then returns the sampled result over a valid/ready channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issuer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [2:0]       alu_cmd,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_cmd,
  output logic [31:0]      rsp_out,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [SETTLE_CNT_W-1:0] c_SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  issuer_state_e           r_state;
  issuer_state_e           w_state_nxt;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic [2:0]              r_alu_cmd;
  logic [31:0]             r_alu_a;
  logic [31:0]             r_alu_b;
  logic [2:0]              r_rsp_cmd;
  logic [31:0]             r_rsp_out;
  logic                    r_rsp_carryout;
  logic                    r_rsp_overflow;
  logic                    r_rsp_zero;
  logic [CNT_W-1:0]        r_op_count;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Retiring goes back to IDLE only; the next accept is a cycle later.
        if (rsp_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_settle_cnt   <= '0;
      r_alu_cmd      <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_rsp_cmd      <= '0;
      r_rsp_out      <= '0;
      r_rsp_carryout <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_op_count     <= '0;
    end else begin
      if (w_accept) begin
        r_alu_cmd    <= req_cmd;
        r_alu_a      <= req_a;
        r_alu_b      <= req_b;
        r_settle_cnt <= c_SETTLE_LOAD;
      end else if (r_state == ST_SETTLE && r_settle_cnt != '0) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_cmd      <= r_alu_cmd;
        r_rsp_out      <= alu_out;
        r_rsp_carryout <= alu_carryout;
        r_rsp_overflow <= alu_overflow;
        r_rsp_zero     <= alu_zero;
      end
      if (w_retire) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign alu_cmd      = r_alu_cmd;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign rsp_cmd      = r_rsp_cmd;
  assign rsp_out      = r_rsp_out;
  assign rsp_carryout = r_rsp_carryout;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign op_count     = r_op_count;

endmodule

`default_nettype wire
